// File: rtl/pre_input_loader_if.sv
// Bundle between the loader, the upstream AXI-Stream source and the transposer input buffer.
// The slave modport is the loader's view; the master modport is the environment's.
interface pre_input_loader_if #(
  parameter int DATA_WIDTH = 39
);
  logic                      s_axis_tvalid;
  logic                      s_axis_tready;
  logic [127:0]              s_axis_tdata;
  logic                      s_axis_tlast;
  logic                      o_ibuf_reset;
  logic                      o_ibuf_wren;
  logic [11:0]               o_ibuf_addr;
  logic [2*DATA_WIDTH-1:0]   o_ibuf_data;
  logic                      i_ibuf_done;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, i_ibuf_done,
    output s_axis_tready, o_ibuf_reset, o_ibuf_wren, o_ibuf_addr, o_ibuf_data
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, i_ibuf_done,
    input  s_axis_tready, o_ibuf_reset, o_ibuf_wren, o_ibuf_addr, o_ibuf_data
  );
endinterface

// File: rtl/pre_input_loader.sv
// Streams one batch of two-lane coefficient beats into the transposer input buffer,
// clearing it first and flagging tlast framing errors without altering the beat count.
module pre_input_loader #(
  parameter int DATA_WIDTH  = 39,
  parameter int BATCH_BEATS = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  pre_input_loader_if.slave  bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, WAIT_DONE} state_t;

  localparam logic [11:0] LAST_BEAT = 12'(BATCH_BEATS - 1);

  state_t                  state_q, state_d;
  logic [11:0]             cnt_q;
  logic                    wren_q;
  logic [11:0]             addr_q;
  logic [2*DATA_WIDTH-1:0] data_q;
  logic                    done_q;
  logic                    err_q;
  logic                    tready;
  logic                    accept;
  logic                    last_beat;

  assign accept    = tready && bus.s_axis_tvalid;
  assign last_beat = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tready           = 1'b0;
    bus.o_ibuf_reset = 1'b0;
    o_busy           = 1'b1;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bus.o_ibuf_reset = 1'b1;
        state_d          = LOAD;
      end
      LOAD: begin
        tready = 1'b1;
        // End of batch is decided by the beat count only, never by tlast.
        if (accept && last_beat) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.i_ibuf_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wren_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wren_q <= accept;
      done_q <= (state_q == WAIT_DONE) && bus.i_ibuf_done;
      if (state_q == CLEAR) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 12'd1;
      end
      if (accept) begin
        addr_q <= cnt_q;
        data_q <= {bus.s_axis_tdata[64 +: DATA_WIDTH], bus.s_axis_tdata[0 +: DATA_WIDTH]};
      end
      // Sticky until a new batch is started from IDLE.
      if ((state_q == IDLE) && i_start) begin
        err_q <= 1'b0;
      end else if (accept && (bus.s_axis_tlast != last_beat)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.o_ibuf_wren   = wren_q;
  assign bus.o_ibuf_addr   = addr_q;
  assign bus.o_ibuf_data   = data_q;
  assign o_done            = done_q;
  assign o_err             = err_q;
endmodule

// File: tb/tb_pre_input_loader.sv
// Randomized batch-level bench for pre_input_loader: expected writes come from the beats the
// bench itself hands over, expected framing errors from the tlast rule applied per beat index.
module tb_pre_input_loader;
  localparam int DW    = 39;
  localparam int BEATS = 2048;

  typedef struct packed {
    logic [11:0]     addr;
    logic [2*DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic i_start;
  logic o_busy;
  logic o_done;
  logic o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int mon_writes = 0;
  int mon_resets = 0;
  int mon_dones  = 0;
  logic [11:0]     last_addr = '0;
  logic [2*DW-1:0] last_data = '0;
  wr_t exp_q[$];

  pre_input_loader_if #(.DATA_WIDTH(DW)) bus();

  pre_input_loader #(.DATA_WIDTH(DW), .BATCH_BEATS(BEATS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor: every write must match the oldest handed-over beat.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (bus.o_ibuf_reset) mon_resets++;
      if (o_done) mon_dones++;
      if (bus.o_ibuf_wren) begin
        mon_writes++;
        if (exp_q.size() == 0) begin
          check_val("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("wr_addr", bus.o_ibuf_addr, e.addr);
          check_val("wr_data", bus.o_ibuf_data, e.data);
        end
        last_addr = bus.o_ibuf_addr;
        last_data = bus.o_ibuf_data;
      end else begin
        check_val("hold_addr", bus.o_ibuf_addr, last_addr);
        check_val("hold_data", bus.o_ibuf_data, last_data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_tready"}, bus.s_axis_tready, 0);
    check_val({tag, "_ibreset"}, bus.o_ibuf_reset, 0);
    check_val({tag, "_wren"}, bus.o_ibuf_wren, 0);
    check_val({tag, "_addr"}, bus.o_ibuf_addr, 0);
    check_val({tag, "_data"}, bus.o_ibuf_data, 0);
    check_val({tag, "_busy"}, o_busy, 0);
    check_val({tag, "_done"}, o_done, 0);
    check_val({tag, "_err"}, o_err, 0);
  endtask

  // One batch; called and returning at posedge+1 with the loader idle.
  task automatic run_batch(input bit counting, input int stall_pct, input int bad_beat,
                           input bit drop_last, input bit poke_load, input int abort_at,
                           input bit start_with_done);
    int k = 0;
    int iter = 0;
    bit err_exp = 1'b0;
    logic [63:0] l0;
    logic [63:0] l1;
    mon_writes = 0;
    mon_resets = 0;
    mon_dones  = 0;
    check_val("idle_busy", o_busy, 0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check_val("clear_ibreset", bus.o_ibuf_reset, 1);
    check_val("clear_busy", o_busy, 1);
    check_val("clear_err", o_err, 0);
    while (k < BEATS) begin
      check_val("load_err", o_err, err_exp);
      check_val("load_tready", bus.s_axis_tready, (iter > 0));
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (counting) begin
        l0 = 64'(k);
        l1 = 64'(k + 4096);
      end else begin
        l0 = {$urandom, $urandom};
        l1 = {$urandom, $urandom};
      end
      bus.s_axis_tvalid = ($urandom_range(99) >= stall_pct);
      bus.s_axis_tdata  = {l1, l0};
      bus.s_axis_tlast  = (k == bad_beat) || (k == BEATS - 1 && !drop_last);
      if (poke_load && iter == 300) begin
        i_start         = 1'b1;
        bus.i_ibuf_done = 1'b1;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        exp_q.push_back({k[11:0], l1[DW-1:0], l0[DW-1:0]});
        if (bus.s_axis_tlast != (k == BEATS - 1)) err_exp = 1'b1;
        k++;
      end
      iter++;
      @(posedge clk); #1;
      i_start         = 1'b0;
      bus.i_ibuf_done = 1'b0;
      if (iter > 20000) begin
        check_val("load_timeout", k, BEATS);
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check_val("wait_tready", bus.s_axis_tready, 0);
    check_val("wait_busy", o_busy, 1);
    check_val("wait_err", o_err, err_exp);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_val("wait_nodone", o_done, 0);
      check_val("wait_tready_hold", bus.s_axis_tready, 0);
    end
    bus.i_ibuf_done = 1'b1;
    i_start         = start_with_done;
    @(posedge clk); #1;
    bus.i_ibuf_done = 1'b0;
    i_start         = 1'b0;
    check_val("done_pulse", o_done, 1);
    check_val("done_idle", o_busy, 0);
    @(posedge clk); #1;
    check_val("done_single", o_done, 0);
    check_val("after_idle", o_busy, 0);
    check_val("after_err", o_err, err_exp);
    check_val("batch_writes", mon_writes, BEATS);
    check_val("batch_ibreset", mon_resets, 1);
    check_val("batch_dones", mon_dones, 1);
    check_val("batch_leftover", exp_q.size(), 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    i_start           = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.i_ibuf_done   = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    run_batch(1, 0,  -1,  0, 0, -1,   0);  // nominal back-to-back counting batch
    run_batch(0, 50, -1,  0, 0, -1,   0);  // 50% stalls, random lanes
    run_batch(0, 20, 100, 0, 1, -1,   0);  // early tlast, start/done poked during LOAD
    run_batch(0, 10, -1,  0, 0, -1,   0);  // start clears sticky error
    run_batch(0, 30, -1,  1, 0, -1,   1);  // missing final tlast, start with done
    run_batch(0, 30, -1,  0, 0, 1000, 0);  // reset mid-batch
    run_batch(1, 30, -1,  0, 0, -1,   0);  // fresh batch after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pre_input_loader.md
PRE_INPUT_LOADER -- requirements
Module: pre_input_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 39, coefficient width in bits.
REQ-002 SHALL have parameter BATCH_BEATS, default 2048, beats per batch; legal range 1..2048.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  one-cycle pulse that begins a batch; honoured only in IDLE.
REQ-006 s_axis_tvalid  input  1  upstream beat valid.
REQ-007 s_axis_tready  output  1  beat accept.
REQ-008 s_axis_tdata  input  128  lane0 = [63:0], lane1 = [127:64]; each coefficient is in the lane's low DATA_WIDTH bits.
REQ-009 s_axis_tlast  input  1  last beat of the batch.
REQ-010 o_ibuf_reset  output  1  clear pulse to the transposer.
REQ-011 o_ibuf_wren  output  1  write strobe to the transposer.
REQ-012 o_ibuf_addr  output  12  write address, 0..BATCH_BEATS-1.
REQ-013 o_ibuf_data  output  2*DATA_WIDTH  {lane1 coeff, lane0 coeff}.
REQ-014 i_ibuf_done  input  1  transposer reports the batch is stored.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-cycle batch-complete pulse.
REQ-017 o_err  output  1  sticky tlast-framing error flag.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, LOAD, WAIT_DONE.
- IDLE->CLEAR on i_start.
- CLEAR->LOAD after exactly one cycle.
- LOAD->WAIT_DONE on acceptance of beat BATCH_BEATS-1.
- WAIT_DONE->IDLE on i_ibuf_done.
REQ-019 o_ibuf_reset SHALL be high for exactly the single CLEAR cycle.
REQ-020 s_axis_tready SHALL be high only in LOAD; a beat is accepted when tvalid and tready are both high in the same cycle.
REQ-021 Beat counter SHALL be 12-bit, cleared in CLEAR, incremented per accepted beat; it SHALL NOT wrap within a batch.
REQ-022 Per accepted beat, on the next cycle the block SHALL drive o_ibuf_wren=1, o_ibuf_addr=counter value at acceptance, o_ibuf_data={tdata[64+:DATA_WIDTH], tdata[0+:DATA_WIDTH]}; latency is 1 cycle, fully registered.
REQ-023 o_ibuf_wren SHALL be 0 in every cycle that does not follow an accepted beat; o_ibuf_addr and o_ibuf_data SHALL hold their last value when wren is 0.
REQ-024 Upstream stalls (tvalid low) SHALL insert gaps with no lost or duplicated addresses.
REQ-025 tlast SHALL be checked on each accepted beat.
- tlast=1 on a beat other than BATCH_BEATS-1: set o_err.
- tlast=0 on beat BATCH_BEATS-1: set o_err.
- The beat count alone SHALL determine the end of the batch; framing errors SHALL NOT change the state sequence.
REQ-026 o_err SHALL clear only on reset or on i_start accepted in IDLE.
REQ-027 o_done SHALL pulse in the cycle after i_ibuf_done is sampled high in WAIT_DONE, coincident with the return to IDLE.
REQ-028 i_ibuf_done SHALL be ignored outside WAIT_DONE.
REQ-029 i_start outside IDLE SHALL be ignored, with no effect on the state, counter or o_err.
REQ-030 i_start and i_ibuf_done high in the same WAIT_DONE cycle: the block SHALL go to IDLE and drop the start pulse.

Reset
REQ-031 On rst_n low, asynchronously:
- state=IDLE, counter=0;
- s_axis_tready, o_ibuf_reset, o_ibuf_wren, o_busy, o_done and o_err = 0;
- o_ibuf_addr=0, o_ibuf_data=0.
REQ-032 Reset mid-batch SHALL abandon the batch; the next i_start SHALL issue a fresh CLEAR and restart at address 0.

Verification
REQ-033 Nominal batch: i_start, then 2048 back-to-back beats with lane0=k, lane1=k+4096, tlast on beat 2047, then i_ibuf_done 5 cycles later -> one o_ibuf_reset pulse; 2048 wren cycles with addr=k and data={k+4096,k}; o_done 1 cycle after done; o_err=0.
REQ-034 Stalls: tvalid toggled randomly at 50% -> addresses contiguous 0..2047, no duplicates; tready low in CLEAR and WAIT_DONE.
REQ-035 Framing: tlast on beat 100 -> o_err=1 from the cycle after beat 100; the batch still completes 2048 writes; the next i_start clears o_err.
REQ-036 Missing tlast on beat 2047 -> o_err=1, state WAIT_DONE; i_ibuf_done -> o_done.
REQ-037 Reset at beat 1000 -> all outputs 0 immediately; a new batch writes addr 0 first, preceded by one o_ibuf_reset.
REQ-038 i_start during LOAD and an early i_ibuf_done during LOAD -> both ignored; o_done appears only after a done received in WAIT_DONE.
